ecd_speed_meas: RTL

- Downstream consumer of the quadrature decoder's 32-bit position count (one instance per axis X/Y/A/B, and one for the handwheel M).
- Samples the count at a fixed period and computes the signed per-period displacement.
- Keeps a moving average over 2^AVG_LOG2 periods and flags over-speed against a host-programmed limit.
- Outputs feed the host register file and the motion-control servo loop.

---
 rtl/ecd_speed_meas.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ecd_speed_meas.sv
// rtl/ecd_speed_meas.sv - per-period displacement, moving-average speed and over-speed flag
// Samples the decoder count every PERIOD cycles; fixed 3-cycle latency from tick to spd_valid.
module ecd_speed_meas #(
    parameter int PERIOD   = 100000,
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk_100M,
    input  logic        n_rst,
    input  logic        en,
    input  logic        clr,
    input  logic        ecd_rst_n,
    input  logic [31:0] ecd_value,
    input  logic [31:0] spd_limit,
    output logic [31:0] delta,
    output logic [31:0] speed,
    output logic        spd_valid,
    output logic        ready,
    output logic        overspd
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 34 + AVG_LOG2;
    localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TW    = $clog2(PERIOD);
    localparam logic [AVG_LOG2:0] FILL_MAX = (AVG_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                 state;
    logic [31:0]            cur;
    logic                   cur_rst_n;
    logic [TW-1:0]          timer;
    logic                   tick;
    logic [31:0]            prev;
    logic [31:0]            d1;
    logic [31:0]            d2;
    logic                   p1;
    logic                   p2;
    logic [31:0]            hist [DEPTH];
    logic [PW-1:0]          wptr;
    logic [AVG_LOG2:0]      fill;
    logic signed [SW-1:0]   sum;
    logic signed [SW-1:0]   sum_nxt;
    logic [31:0]            speed_nxt;
    logic [31:0]            oldest;
    logic [32:0]            d_ext;
    logic [32:0]            d_mag;
    logic                   over;

    always_ff @(posedge clk_100M or negedge n_rst) begin
        if (!n_rst) begin
            cur       <= '0;
            cur_rst_n <= 1'b0;
        end else begin
            cur       <= ecd_value;
            cur_rst_n <= ecd_rst_n;
        end
    end

    always_ff @(posedge clk_100M or negedge n_rst) begin
        if (!n_rst) begin
            timer <= '0;
        end else if (!en || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    assign tick = en && (timer == TW'(PERIOD - 1));

    assign oldest    = hist[wptr];
    assign sum_nxt   = sum + {{(SW-32){d1[31]}}, d1} - {{(SW-32){oldest[31]}}, oldest};
    assign speed_nxt = 32'(sum >>> AVG_LOG2);

    // 33-bit magnitude so that -2^31 compares as +2^31
    assign d_ext = {d2[31], d2};
    assign d_mag = d2[31] ? (33'd0 - d_ext) : d_ext;
    assign over  = d_mag > {1'b0, spd_limit};

    always_ff @(posedge clk_100M or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            prev      <= '0;
            d1        <= '0;
            d2        <= '0;
            p1        <= 1'b0;
            p2        <= 1'b0;
            sum       <= '0;
            wptr      <= '0;
            fill      <= '0;
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            delta     <= '0;
            speed     <= '0;
            spd_valid <= 1'b0;
            ready     <= 1'b0;
            overspd   <= 1'b0;
        end else begin
            spd_valid <= 1'b0;
            p1        <= 1'b0;
            p2        <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                sum     <= '0;
                wptr    <= '0;
                fill    <= '0;
                for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
                ready   <= 1'b0;
                overspd <= 1'b0;
            end else if (state == IDLE) begin
                state <= PRIME;
            end else if (clr || !cur_rst_n) begin
                // re-prime on the next clean tick so a count reset never shows up as a jump
                state <= PRIME;
                sum   <= '0;
                wptr  <= '0;
                fill  <= '0;
                for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
                ready <= 1'b0;
                if (clr) overspd <= 1'b0;
            end else begin
                if (tick) begin
                    prev  <= cur;
                    d1    <= cur - prev;
                    p1    <= (state == RUN);
                    state <= RUN;
                end
                if (p1) begin
                    sum        <= sum_nxt;
                    hist[wptr] <= d1;
                    wptr       <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
                    if (fill != FILL_MAX) fill <= fill + (AVG_LOG2 + 1)'(1);
                    d2         <= d1;
                    p2         <= 1'b1;
                end
                if (p2) begin
                    delta     <= d2;
                    speed     <= speed_nxt;
                    spd_valid <= 1'b1;
                    ready     <= (fill == FILL_MAX);
                    if (over) overspd <= 1'b1;
                end
            end
        end
    end

endmodule
